dcache_flush_ctrl: RTL and testbench



---
 rtl/dcache_flush_ctrl_pkg.sv | 29 ++
 rtl/dcache_flush_ctrl_if.sv | 51 +++++
 rtl/dcache_victim_sel.sv | 30 +++
 rtl/dcache_flush_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcache_flush_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_flush_ctrl_pkg.sv
// Shared definitions for the dcache miss/flush sequencer: FSM encoding,
// default geometry and the address-split helpers.
package dcache_flush_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WB_RD  = 3'd1,
    ST_WB_WR  = 3'd2,
    ST_FILL   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam int DEF_DATABITS      = 32;
  localparam int DEF_ADDRBITS      = 32;
  localparam int DEF_CACHEADDRBITS = 5;
  localparam int DEF_LSBITS        = 2;
  localparam int DEF_LINENUM       = 4;
  localparam int DEF_CNTMISSBITS   = 8;

  function automatic int line_words(input int cacheaddrbits);
    return 1 << cacheaddrbits;
  endfunction

  // Lowest address bit that belongs to the line tag.
  function automatic int tag_lsb(input int cacheaddrbits, input int lsbits);
    return cacheaddrbits + lsbits;
  endfunction

endpackage

// File: rtl/dcache_flush_ctrl_if.sv
// Bundle of CPU-side, cache-line-side and memory-side signals seen by the
// flush controller; master is the controller, slave is its environment.
interface dcache_flush_ctrl_if import dcache_flush_ctrl_pkg::*; #(
  parameter int DATABITS      = DEF_DATABITS,
  parameter int ADDRBITS      = DEF_ADDRBITS,
  parameter int CACHEADDRBITS = DEF_CACHEADDRBITS,
  parameter int LINENUM       = DEF_LINENUM,
  parameter int CNTMISSBITS   = DEF_CNTMISSBITS
);

  logic [ADDRBITS-1:0]             dcache_addr;
  logic                            dcache_rdreq;
  logic                            dcache_wrreq;
  logic                            dcache_stall;
  logic [LINENUM-1:0]              line_miss;
  logic [LINENUM-1:0]              line_dirty;
  logic [LINENUM*CNTMISSBITS-1:0]  flush_cnt_miss;
  logic [LINENUM*ADDRBITS-1:0]     line_wbaddr;
  logic [DATABITS-1:0]             line_rddata;
  logic [LINENUM-1:0]              flush_mode;
  logic                            flush_write;
  logic [CACHEADDRBITS-1:0]        flush_addr;
  logic                            flush_dirty;
  logic [DATABITS-1:0]             line_in;
  logic                            line_in_valid;
  logic [ADDRBITS-1:0]             mem_addr;
  logic                            mem_rdreq;
  logic                            mem_wrreq;
  logic [DATABITS-1:0]             mem_wrdata;
  logic [DATABITS-1:0]             mem_rddata;
  logic                            mem_valid;

  modport master (
    input  dcache_addr, dcache_rdreq, dcache_wrreq,
    input  line_miss, line_dirty, flush_cnt_miss, line_wbaddr, line_rddata,
    input  mem_rddata, mem_valid,
    output dcache_stall,
    output flush_mode, flush_write, flush_addr, flush_dirty, line_in, line_in_valid,
    output mem_addr, mem_rdreq, mem_wrreq, mem_wrdata
  );

  modport slave (
    output dcache_addr, dcache_rdreq, dcache_wrreq,
    output line_miss, line_dirty, flush_cnt_miss, line_wbaddr, line_rddata,
    output mem_rddata, mem_valid,
    input  dcache_stall,
    input  flush_mode, flush_write, flush_addr, flush_dirty, line_in, line_in_valid,
    input  mem_addr, mem_rdreq, mem_wrreq, mem_wrdata
  );

endinterface

// File: rtl/dcache_victim_sel.sv
// Combinational victim picker: one-hot select of the line with the largest
// miss counter, ties resolved towards the lowest line index.
module dcache_victim_sel import dcache_flush_ctrl_pkg::*; #(
  parameter int LINENUM     = DEF_LINENUM,
  parameter int CNTMISSBITS = DEF_CNTMISSBITS
) (
  input  logic [LINENUM*CNTMISSBITS-1:0] i_cnt,
  output logic [LINENUM-1:0]             o_victim
);

  logic [CNTMISSBITS-1:0] w_best_val;
  int                     w_best_idx;

  // Strict greater-than keeps the earlier (lower) index on equal counts.
  always_comb begin
    w_best_val = i_cnt[0 +: CNTMISSBITS];
    w_best_idx = 0;
    for (int i = 1; i < LINENUM; i++) begin
      if (i_cnt[i*CNTMISSBITS +: CNTMISSBITS] > w_best_val) begin
        w_best_val = i_cnt[i*CNTMISSBITS +: CNTMISSBITS];
        w_best_idx = i;
      end
    end
    o_victim = '0;
    for (int i = 0; i < LINENUM; i++) begin
      o_victim[i] = (i == w_best_idx);
    end
  end

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Miss sequencer behind the dcache lines: picks a victim, writes it back if
// dirty, refills it word by word from memory and commits the new tag.
module dcache_flush_ctrl import dcache_flush_ctrl_pkg::*; #(
  parameter int DATABITS      = DEF_DATABITS,
  parameter int ADDRBITS      = DEF_ADDRBITS,
  parameter int CACHEADDRBITS = DEF_CACHEADDRBITS,
  parameter int LSBITS        = DEF_LSBITS,
  parameter int CACHESIZE     = line_words(CACHEADDRBITS),
  parameter int LINENUM       = DEF_LINENUM,
  parameter int CNTMISSBITS   = DEF_CNTMISSBITS
) (
  input logic               clk,
  input logic               reset,
  dcache_flush_ctrl_if.master bus
);

  localparam int TAGLSB = tag_lsb(CACHEADDRBITS, LSBITS);
  localparam logic [CACHEADDRBITS-1:0] CNT_LAST = CACHEADDRBITS'(CACHESIZE - 1);

  state_t                     r_state;
  logic [CACHEADDRBITS-1:0]   r_cnt;
  logic [LINENUM-1:0]         r_victim;
  logic [ADDRBITS-TAGLSB-1:0] r_tag;
  logic [ADDRBITS-1:0]        r_wbaddr;
  logic                       r_wr;
  logic [DATABITS-1:0]        r_wrdata;
  logic                       r_wr_hold;

  logic [LINENUM-1:0]         w_victim;
  logic                       w_vic_dirty;
  logic [ADDRBITS-1:0]        w_vic_wbaddr;
  logic                       w_miss;
  logic                       w_cnt_last;
  logic                       w_unused_addr_lsb;

  dcache_victim_sel #(
    .LINENUM     (LINENUM),
    .CNTMISSBITS (CNTMISSBITS)
  ) u_victim_sel (
    .i_cnt    (bus.flush_cnt_miss),
    .o_victim (w_victim)
  );

  assign w_miss            = (bus.dcache_rdreq | bus.dcache_wrreq) & (&bus.line_miss);
  assign w_vic_dirty       = |(w_victim & bus.line_dirty);
  assign w_cnt_last        = (r_cnt == CNT_LAST);
  assign w_unused_addr_lsb = ^bus.dcache_addr[TAGLSB-1:0];

  always_comb begin
    w_vic_wbaddr = '0;
    for (int i = 0; i < LINENUM; i++) begin
      if (w_victim[i]) w_vic_wbaddr |= bus.line_wbaddr[i*ADDRBITS +: ADDRBITS];
    end
  end

  // Sequencer state; data captures are left out of the reset branch since
  // every output that exposes them is gated by the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wr_hold <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_wr_hold <= 1'b0;
          if (w_miss) begin
            r_victim <= w_victim;
            r_tag    <= bus.dcache_addr[ADDRBITS-1:TAGLSB];
            r_wbaddr <= w_vic_wbaddr;
            r_wr     <= bus.dcache_wrreq;
            r_state  <= w_vic_dirty ? ST_WB_RD : ST_FILL;
          end
        end
        ST_WB_RD: begin
          r_wr_hold <= 1'b0;
          r_state   <= ST_WB_WR;
        end
        ST_WB_WR: begin
          if (bus.mem_valid) begin
            r_wr_hold <= 1'b0;
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= ST_FILL;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= ST_WB_RD;
            end
          end else if (!r_wr_hold) begin
            r_wrdata  <= bus.line_rddata;
            r_wr_hold <= 1'b1;
          end
        end
        ST_FILL: begin
          if (bus.mem_valid) begin
            if (w_cnt_last) begin
              r_cnt   <= '0;
              r_state <= ST_COMMIT;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The victim word read in WB_RD arrives on line_rddata during the first
  // WB_WR cycle; it is forwarded there and held in r_wrdata while waiting.
  always_comb begin
    bus.dcache_stall  = (r_state != ST_IDLE) | w_miss;
    bus.flush_mode    = '0;
    bus.flush_write   = 1'b0;
    bus.flush_addr    = '0;
    bus.flush_dirty   = 1'b0;
    bus.line_in       = '0;
    bus.line_in_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_rdreq     = 1'b0;
    bus.mem_wrreq     = 1'b0;
    bus.mem_wrdata    = '0;
    case (r_state)
      ST_WB_RD: begin
        bus.flush_mode = r_victim;
        bus.flush_addr = r_cnt;
      end
      ST_WB_WR: begin
        bus.flush_mode = r_victim;
        bus.flush_addr = r_cnt;
        bus.mem_wrreq  = 1'b1;
        bus.mem_addr   = r_wbaddr + (ADDRBITS'(r_cnt) << LSBITS);
        bus.mem_wrdata = r_wr_hold ? r_wrdata : bus.line_rddata;
      end
      ST_FILL: begin
        bus.mem_rdreq = 1'b1;
        bus.mem_addr  = {r_tag, r_cnt, {LSBITS{1'b0}}};
        if (bus.mem_valid) begin
          bus.line_in       = bus.mem_rddata;
          bus.line_in_valid = 1'b1;
          bus.flush_write   = 1'b1;
          bus.flush_mode    = r_victim;
          bus.flush_addr    = r_cnt;
        end
      end
      ST_COMMIT: begin
        bus.flush_mode  = r_victim;
        bus.flush_write = 1'b1;
        bus.flush_dirty = r_wr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl: table of single-cycle victim/hit
// vectors plus full miss sequences against a simple memory and line model.
module tb_dcache_flush_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic wait_mode;
  int   wcnt;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dcache_flush_ctrl_if bus ();

  dcache_flush_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  function automatic logic [31:0] line_pat(input logic [4:0] a);
    return 32'hD000_0000 | (32'(a) * 32'h111);
  endfunction

  function automatic logic [31:0] mem_pat(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  // Line read port: data for flush_addr appears one cycle later.
  always @(posedge clk) bus.line_rddata <= line_pat(bus.flush_addr);

  always_comb begin
    bus.mem_valid  = (bus.mem_rdreq | bus.mem_wrreq) & (!wait_mode | (wcnt == 2));
    bus.mem_rddata = mem_pat(bus.mem_addr);
  end

  always @(posedge clk) begin
    if ((bus.mem_rdreq | bus.mem_wrreq) && !bus.mem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_flush_mode"},    64'(bus.flush_mode), 0);
    check({nm, "_flush_write"},   64'(bus.flush_write), 0);
    check({nm, "_flush_addr"},    64'(bus.flush_addr), 0);
    check({nm, "_flush_dirty"},   64'(bus.flush_dirty), 0);
    check({nm, "_line_in"},       64'(bus.line_in), 0);
    check({nm, "_line_in_valid"}, 64'(bus.line_in_valid), 0);
    check({nm, "_mem_addr"},      64'(bus.mem_addr), 0);
    check({nm, "_mem_rdreq"},     64'(bus.mem_rdreq), 0);
    check({nm, "_mem_wrreq"},     64'(bus.mem_wrreq), 0);
    check({nm, "_mem_wrdata"},    64'(bus.mem_wrdata), 0);
    check({nm, "_stall"},         64'(bus.dcache_stall), 0);
  endtask

  typedef struct {
    logic [31:0] cnts;
    logic [3:0]  miss;
    logic        rd;
    logic        wr;
    logic [3:0]  dirty;
    logic        exp_stall;
    logic [3:0]  exp_mode;
    logic        exp_req;
  } vec_t;

  vec_t vecs[8];

  task automatic do_miss(input string nm, input logic [31:0] addr, input logic wr,
                         input logic [31:0] cnts, input logic [3:0] dirty, input int vic,
                         input logic [31:0] wbaddr, input logic exp_wb,
                         input int exp_stall, input int abort_beat);
    int          stall_n = 0;
    int          wi = 0;
    int          fi = 0;
    int          ncommit = 0;
    logic        done = 1'b0;
    logic        p_pend = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;
    logic        p_rd = 1'b0;
    logic        p_wr = 1'b0;
    logic [31:0] base;
    logic [3:0]  vmask;
    vmask = 4'b0001 << vic;
    base  = addr & ~32'h7F;
    @(negedge clk);
    for (int i = 0; i < 4; i++) bus.line_wbaddr[i*32 +: 32] = 32'hF000_0000 | (32'(i) << 12);
    bus.line_wbaddr[vic*32 +: 32] = wbaddr;
    bus.flush_cnt_miss = cnts;
    bus.line_dirty     = dirty;
    bus.line_miss      = 4'hF;
    bus.dcache_addr    = addr;
    bus.dcache_rdreq   = !wr;
    bus.dcache_wrreq   = wr;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      #1;
      if (cyc == 1) bus.dcache_addr = 32'hFFFF_FFFC;
      if (bus.dcache_stall) stall_n++;
      if (p_pend) begin
        check({nm, "_hold_addr"},  64'(bus.mem_addr), 64'(p_addr));
        check({nm, "_hold_data"},  64'(bus.mem_wrdata), 64'(p_data));
        check({nm, "_hold_rdreq"}, 64'(bus.mem_rdreq), 64'(p_rd));
        check({nm, "_hold_wrreq"}, 64'(bus.mem_wrreq), 64'(p_wr));
      end
      p_pend = (bus.mem_rdreq | bus.mem_wrreq) & !bus.mem_valid;
      p_addr = bus.mem_addr;
      p_data = bus.mem_wrdata;
      p_rd   = bus.mem_rdreq;
      p_wr   = bus.mem_wrreq;
      if (bus.mem_valid && bus.mem_wrreq) begin
        check({nm, "_wb_addr"}, 64'(bus.mem_addr), 64'(wbaddr + 32'(wi) * 4));
        check({nm, "_wb_data"}, 64'(bus.mem_wrdata), 64'(line_pat(5'(wi))));
        wi++;
      end
      if (bus.mem_valid && bus.mem_rdreq) begin
        check({nm, "_fill_addr"},  64'(bus.mem_addr), 64'(base + 32'(fi) * 4));
        check({nm, "_fill_widx"},  64'(bus.flush_addr), 64'(fi));
        check({nm, "_fill_mode"},  64'(bus.flush_mode), 64'(vmask));
        check({nm, "_fill_data"},  64'(bus.line_in), 64'(mem_pat(base + 32'(fi) * 4)));
        check({nm, "_fill_strb"},  64'({bus.line_in_valid, bus.flush_write}), 64'b11);
        if (fi == abort_beat) begin
          reset = 1'b1;
          bus.dcache_rdreq = 1'b0;
          bus.dcache_wrreq = 1'b0;
          @(negedge clk);
          #1;
          check_zero({nm, "_rst"});
          reset = 1'b0;
          return;
        end
        fi++;
      end
      if (ncommit > 0) begin
        check({nm, "_stall_drop"}, 64'(bus.dcache_stall), 0);
        done = 1'b1;
      end else if (bus.flush_write && !bus.line_in_valid) begin
        ncommit++;
        check({nm, "_commit_mode"},  64'(bus.flush_mode), 64'(vmask));
        check({nm, "_commit_dirty"}, 64'(bus.flush_dirty), 64'(wr));
        bus.dcache_rdreq = 1'b0;
        bus.dcache_wrreq = 1'b0;
        bus.line_miss    = 4'h0;
      end
      if (!done) @(negedge clk);
    end
    check({nm, "_finished"},  64'(done), 1);
    check({nm, "_wb_beats"},  64'(wi), exp_wb ? 64'd32 : 64'd0);
    check({nm, "_fill_beats"}, 64'(fi), 32);
    check({nm, "_commits"},   64'(ncommit), 1);
    check({nm, "_stall_cyc"}, 64'(stall_n), 64'(exp_stall));
  endtask

  initial begin
    //            cnts {l3,l2,l1,l0}               miss    rd    wr    dirty   stall mode    req
    vecs[0] = '{{8'd1, 8'd9, 8'd9, 8'd3},         4'b1011, 1'b1, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0};
    vecs[1] = '{{8'd1, 8'd9, 8'd9, 8'd3},         4'b0000, 1'b0, 1'b1, 4'h0, 1'b0, 4'b0000, 1'b0};
    vecs[2] = '{{8'd1, 8'd9, 8'd9, 8'd3},         4'b1111, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0};
    vecs[3] = '{{8'd1, 8'd9, 8'd9, 8'd3},         4'b1111, 1'b1, 1'b0, 4'h0, 1'b1, 4'b0010, 1'b1};
    vecs[4] = '{{8'd255, 8'd255, 8'd255, 8'd255}, 4'b1111, 1'b1, 1'b0, 4'h0, 1'b1, 4'b0001, 1'b1};
    vecs[5] = '{{8'd7, 8'd0, 8'd0, 8'd0},         4'b1111, 1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b1};
    vecs[6] = '{{8'd10, 8'd201, 8'd200, 8'd5},    4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0};
    vecs[7] = '{{8'd10, 8'd201, 8'd200, 8'd5},    4'b1111, 1'b0, 1'b1, 4'b1011, 1'b1, 4'b0100, 1'b1};

    reset              = 1'b1;
    wait_mode          = 1'b0;
    bus.dcache_addr    = '0;
    bus.dcache_rdreq   = 1'b0;
    bus.dcache_wrreq   = 1'b0;
    bus.line_miss      = '0;
    bus.line_dirty     = '0;
    bus.flush_cnt_miss = '0;
    bus.line_wbaddr    = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.flush_cnt_miss = vecs[k].cnts;
      bus.line_miss      = vecs[k].miss;
      bus.line_dirty     = vecs[k].dirty;
      bus.dcache_rdreq   = vecs[k].rd;
      bus.dcache_wrreq   = vecs[k].wr;
      bus.dcache_addr    = 32'h0000_0500;
      #1;
      check($sformatf("vec%0d_stall", k), 64'(bus.dcache_stall), 64'(vecs[k].exp_stall));
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_mode", k), 64'(bus.flush_mode), 64'(vecs[k].exp_mode));
      check($sformatf("vec%0d_req", k), 64'(bus.mem_rdreq | bus.mem_wrreq), 64'(vecs[k].exp_req));
      reset            = 1'b1;
      bus.dcache_rdreq = 1'b0;
      bus.dcache_wrreq = 1'b0;
      bus.line_miss    = '0;
      @(negedge clk);
      reset = 1'b0;
    end

    do_miss("clean", 32'h0000_1280, 1'b0, {8'd1, 8'd9, 8'd9, 8'd3}, 4'h0, 1,
            32'h0, 1'b0, 34, -1);
    do_miss("dirty", 32'h0000_8A44, 1'b1, {8'd10, 8'd201, 8'd200, 8'd5}, 4'b0100, 2,
            32'h0000_4000, 1'b1, 98, -1);
    wait_mode = 1'b1;
    do_miss("waits", 32'h0000_2100, 1'b1, {8'd10, 8'd201, 8'd200, 8'd5}, 4'b0100, 2,
            32'h0000_6000, 1'b1, 226, -1);
    wait_mode = 1'b0;
    do_miss("abort", 32'h0000_1280, 1'b0, {8'd1, 8'd9, 8'd9, 8'd3}, 4'h0, 1,
            32'h0, 1'b0, 34, 10);
    do_miss("restart", 32'h0000_3A00, 1'b0, {8'd255, 8'd255, 8'd255, 8'd255}, 4'h0, 0,
            32'h0, 1'b0, 34, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
